// File: rtl/drain_pkg.sv
// Shared constants and FSM encoding for the sorted-array drain stage.
// Widths, memory map and state codes used by the drain top and its bench.
package drain_pkg;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 8;
  localparam int SIZE_ADDR = 255;
  localparam int MAX_N     = 255;

  typedef logic [2:0] state_t;

  localparam state_t IDLE    = 3'd0;
  localparam state_t RD_N    = 3'd1;
  localparam state_t WAIT_N  = 3'd2;
  localparam state_t RD_EL   = 3'd3;
  localparam state_t WAIT_EL = 3'd4;
  localparam state_t SEND    = 3'd5;
  localparam state_t FIN     = 3'd6;

endpackage

// File: rtl/sorted_array_drain_if.sv
// Memory read port plus valid/ready element stream of the drain stage.
// master: drain side (drives reads and stream); slave: memory/consumer.
interface sorted_array_drain_if #(
  parameter int DW = 32,
  parameter int AW = 8
) ();

  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rd_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;

  modport master (
    output mem_rd_en, mem_addr,
    input  mem_rd_data,
    output out_valid, out_data, out_last,
    input  out_ready
  );

  modport slave (
    input  mem_rd_en, mem_addr,
    output mem_rd_data,
    input  out_valid, out_data, out_last,
    output out_ready
  );

endinterface

// File: rtl/sorted_array_drain_order_checker.sv
// Sticky non-decreasing order checker over a stream of sampled values.
// Ports: clk, rst, clear, sample_en, value -> violation (includes current).
module order_checker #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         sample_en,
  input  logic [W-1:0] value,
  output logic         violation
);

  logic [W-1:0] prev_q;
  logic         pv_q;
  logic         viol_q;
  logic         bad;

  // Violation seen combinationally so the last beat counts in the verdict.
  assign bad       = sample_en && pv_q && (value < prev_q);
  assign violation = viol_q | bad;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      prev_q <= '0;
      pv_q   <= 1'b0;
      viol_q <= 1'b0;
    end else if (sample_en) begin
      prev_q <= value;
      pv_q   <= 1'b1;
      viol_q <= viol_q | bad;
    end
  end

endmodule

// File: rtl/sorted_array_drain.sv
// Drains n (read from SIZE_ADDR) memory words onto a valid/ready stream.
// Ports: clk, rst, start, bus (master), busy, done, sorted_ok, err_len.
module sorted_array_drain
  import drain_pkg::*;
#(
  parameter int DW    = DATA_W,
  parameter int AW    = ADDR_W,
  parameter int SADDR = SIZE_ADDR,
  parameter int MAXN  = MAX_N
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  sorted_array_drain_if.master bus,
  output logic                 busy,
  output logic                 done,
  output logic                 sorted_ok,
  output logic                 err_len
);

  state_t        state_q, state_d;
  logic [AW-1:0] n_q, n_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [DW-1:0] data_q, data_d;
  logic          last_q, last_d;
  logic          ok_q, ok_d;
  logic          err_q, err_d;
  logic          clear;
  logic          hs;
  logic          viol;

  assign hs            = (state_q == SEND) && bus.out_ready;
  assign bus.out_valid = (state_q == SEND);
  assign bus.out_data  = data_q;
  assign bus.out_last  = last_q;
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == FIN);
  assign sorted_ok     = ok_q;
  assign err_len       = err_q;

  order_checker #(.W(DW)) u_chk (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .sample_en (hs),
    .value     (data_q),
    .violation (viol)
  );

  always_comb begin
    state_d       = state_q;
    n_d           = n_q;
    idx_d         = idx_q;
    data_d        = data_q;
    last_d        = last_q;
    ok_d          = ok_q;
    err_d         = err_q;
    clear         = 1'b0;
    bus.mem_rd_en = 1'b0;
    bus.mem_addr  = '0;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (start) begin
          state_d = RD_N;
          ok_d    = 1'b0;
          err_d   = 1'b0;
          clear   = 1'b1;
        end
      end
      (state_q == RD_N): begin
        bus.mem_rd_en = 1'b1;
        bus.mem_addr  = AW'(SADDR);
        state_d       = WAIT_N;
      end
      (state_q == WAIT_N): begin
        // Full-width compare; only low bits serve as the count.
        n_d = bus.mem_rd_data[AW-1:0];
        if (bus.mem_rd_data > DW'(MAXN)) begin
          err_d   = 1'b1;
          state_d = FIN;
        end else if (bus.mem_rd_data == '0) begin
          ok_d    = 1'b1;
          state_d = FIN;
        end else begin
          idx_d   = '0;
          state_d = RD_EL;
        end
      end
      (state_q == RD_EL): begin
        bus.mem_rd_en = 1'b1;
        bus.mem_addr  = idx_q;
        state_d       = WAIT_EL;
      end
      (state_q == WAIT_EL): begin
        data_d  = bus.mem_rd_data;
        last_d  = (idx_q == n_q - AW'(1));
        state_d = SEND;
      end
      (state_q == SEND): begin
        if (hs) begin
          if (last_q) begin
            ok_d    = !viol;
            state_d = FIN;
          end else begin
            idx_d   = idx_q + AW'(1);
            state_d = RD_EL;
          end
        end
      end
      (state_q == FIN): begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      n_q     <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      last_q  <= last_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
    end
  end

endmodule
